// File: rtl/acorn_pkg.sv
// acorn_pkg: shared encodings and schedule constants for the ACORN-128
// phase controller and its step decoder.
package acorn_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_INIT = 3'd1,
    PH_AD   = 3'd2,
    PH_ENC  = 3'd3,
    PH_FIN  = 3'd4
  } phase_t;

  typedef enum logic [2:0] {
    SRC_ZERO    = 3'd0,
    SRC_ONE     = 3'd1,
    SRC_KEY     = 3'd2,
    SRC_IV      = 3'd3,
    SRC_AD      = 3'd4,
    SRC_PT      = 3'd5,
    SRC_KEY_INV = 3'd6
  } msrc_t;

  localparam int INIT_STEPS = 1792;
  localparam int FIN_STEPS  = 768;
  localparam int TAG_START  = 640;
  localparam int PAD_STEPS  = 256;
  localparam int CA_TAIL    = 128;

endpackage

// File: rtl/acorn_step_decode.sv
// acorn_step_decode: purely combinational map from (phase, step index) to
// the ACORN control bits, message-bit source/index and ct/tag windows.
module acorn_step_decode
  import acorn_pkg::*;
#(
  parameter int AD_BITS = 128,
  parameter int PT_BITS = 128
) (
  input  phase_t      phase,
  input  logic [10:0] i,
  output logic        ca,
  output logic        cb,
  output logic [2:0]  m_src,
  output logic [9:0]  m_idx,
  output logic        ct_win,
  output logic        tag_win,
  output logic [6:0]  tag_idx
);

  localparam logic [10:0] KEY_END    = 11'd128;
  localparam logic [10:0] IV_END     = 11'd256;
  localparam logic [10:0] KEY_INV_AT = 11'(PAD_STEPS);
  localparam logic [10:0] AD_LEN     = 11'(AD_BITS);
  localparam logic [10:0] AD_CA_END  = 11'(AD_BITS + CA_TAIL);
  localparam logic [10:0] PT_LEN     = 11'(PT_BITS);
  localparam logic [10:0] PT_CA_END  = 11'(PT_BITS + CA_TAIL);
  localparam logic [10:0] TAG_AT     = 11'(TAG_START);

  // Decode the current step; ZERO/ONE sources and non-window steps leave indices at 0.
  always_comb begin
    ca      = 1'b0;
    cb      = 1'b0;
    m_src   = SRC_ZERO;
    m_idx   = '0;
    ct_win  = 1'b0;
    tag_win = 1'b0;
    tag_idx = '0;
    case (phase)
      PH_INIT: begin
        ca = 1'b1;
        cb = 1'b1;
        if (i < KEY_END) begin
          m_src = SRC_KEY;
          m_idx = {3'b000, 7'(i)};
        end else if (i < IV_END) begin
          m_src = SRC_IV;
          m_idx = {3'b000, 7'(i - KEY_END)};
        end else if (i == KEY_INV_AT) begin
          m_src = SRC_KEY_INV;
        end else begin
          // key is replayed cyclically after the inverted bit
          m_src = SRC_KEY;
          m_idx = {3'b000, 7'(i - KEY_INV_AT)};
        end
      end
      PH_AD: begin
        cb = 1'b1;
        ca = (i < AD_CA_END);
        if (i < AD_LEN) begin
          m_src = SRC_AD;
          m_idx = 10'(i);
        end else if (i == AD_LEN) begin
          m_src = SRC_ONE;
        end
      end
      PH_ENC: begin
        ca     = (i < PT_CA_END);
        ct_win = (i < PT_LEN);
        if (i < PT_LEN) begin
          m_src = SRC_PT;
          m_idx = 10'(i);
        end else if (i == PT_LEN) begin
          m_src = SRC_ONE;
        end
      end
      PH_FIN: begin
        ca = 1'b1;
        cb = 1'b1;
        if (i >= TAG_AT) begin
          tag_win = 1'b1;
          tag_idx = 7'(i - TAG_AT);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acorn_phase_ctrl.sv
// acorn_phase_ctrl: steps one ACORN-128 state-update/keystream pair through
// INIT, AD, ENC and FIN, then pulses done.
// Build option: ACORN_STEP_STALL_EN -- when defined, step_rdy gates each
// step; when undefined, step_rdy is ignored and the schedule runs unstalled.
module acorn_phase_ctrl
  import acorn_pkg::*;
#(
  parameter int AD_BITS = 128,
  parameter int PT_BITS = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_rdy,
  output logic       step_en,
  output logic       ca,
  output logic       cb,
  output logic [2:0] m_src,
  output logic [9:0] m_idx,
  output logic       ct_valid,
  output logic       tag_valid,
  output logic [6:0] tag_idx,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  localparam logic [10:0] INIT_LAST = 11'(INIT_STEPS - 1);
  localparam logic [10:0] AD_LAST   = 11'(AD_BITS + PAD_STEPS - 1);
  localparam logic [10:0] ENC_LAST  = 11'(PT_BITS + PAD_STEPS - 1);
  localparam logic [10:0] FIN_LAST  = 11'(FIN_STEPS - 1);

  phase_t      phase_p0;
  logic [10:0] i_p0;
  logic        done_p0;
  logic        rdy;
  logic        last;
  logic        ct_win;
  logic        tag_win;

`ifdef ACORN_STEP_STALL_EN
  assign rdy = step_rdy;
`else
  // step_rdy stays on the port for a uniform interface but never stalls here
  assign rdy = step_rdy | 1'b1;
`endif

  assign busy    = (phase_p0 != PH_IDLE);
  assign step_en = busy & rdy;
  assign phase   = phase_p0;
  assign done    = done_p0;

  // Flag the final step index of the current phase.
  always_comb begin
    last = 1'b0;
    case (phase_p0)
      PH_INIT: last = (i_p0 == INIT_LAST);
      PH_AD:   last = (i_p0 == AD_LAST);
      PH_ENC:  last = (i_p0 == ENC_LAST);
      PH_FIN:  last = (i_p0 == FIN_LAST);
      default: last = 1'b0;
    endcase
  end

  // Phase FSM, step counter and one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p0 <= PH_IDLE;
      i_p0     <= '0;
      done_p0  <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (phase_p0 == PH_IDLE) begin
        if (start) begin
          phase_p0 <= PH_INIT;
          i_p0     <= '0;
        end
      end else if (step_en) begin
        if (last) begin
          i_p0 <= '0;
          case (phase_p0)
            PH_INIT: phase_p0 <= PH_AD;
            PH_AD:   phase_p0 <= PH_ENC;
            PH_ENC:  phase_p0 <= PH_FIN;
            default: begin
              phase_p0 <= PH_IDLE;
              done_p0  <= 1'b1;
            end
          endcase
        end else begin
          i_p0 <= i_p0 + 11'd1;
        end
      end
    end
  end

  acorn_step_decode #(
    .AD_BITS(AD_BITS),
    .PT_BITS(PT_BITS)
  ) u_decode (
    .phase  (phase_p0),
    .i      (i_p0),
    .ca     (ca),
    .cb     (cb),
    .m_src  (m_src),
    .m_idx  (m_idx),
    .ct_win (ct_win),
    .tag_win(tag_win),
    .tag_idx(tag_idx)
  );

  assign ct_valid  = ct_win & step_en;
  assign tag_valid = tag_win & step_en;

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// tb_acorn_phase_ctrl: directed bench for the ACORN-128 phase controller
// with default AD_BITS = PT_BITS = 128 (3328 steps per schedule).
module tb_acorn_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step_rdy;
  logic       step_en;
  logic       ca;
  logic       cb;
  logic [2:0] m_src;
  logic [9:0] m_idx;
  logic       ct_valid;
  logic       tag_valid;
  logic [6:0] tag_idx;
  logic [2:0] phase;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  acorn_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step_rdy (step_rdy),
    .step_en  (step_en),
    .ca       (ca),
    .cb       (cb),
    .m_src    (m_src),
    .m_idx    (m_idx),
    .ct_valid (ct_valid),
    .tag_valid(tag_valid),
    .tag_idx  (tag_idx),
    .phase    (phase),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one schedule from its first busy cycle; k counts accepted steps.
  task automatic run(input int stop_k, output int done_k, output int cyc);
    int k = 0;
    bit enc_pulsed = 0;
    int ct_cnt = 0, tag_cnt = 0, tag_bad = 0, en_bad = 0;
    bit hold = 0;
    logic [24:0] snap = '0;
    logic [24:0] now;
    logic exp_en;
    done_k = -1;
    cyc = 0;
    while (cyc < 20000) begin
      step_rdy = ($urandom_range(0, 1) == 1);
      start = (phase == 3'd3) && (k == 2300) && !enc_pulsed;
      if (start) enc_pulsed = 1;
      #1;
      if (k == stop_k) break;
      if (done) begin
        done_k = k;
        break;
      end
`ifdef ACORN_STEP_STALL_EN
      exp_en = step_rdy;
      now = {phase, ca, cb, m_src, m_idx, tag_idx};
      if (hold) chk("hold_stable", now, snap);
      hold = !step_en;
      snap = now;
`else
      exp_en = 1'b1;
`endif
      if (step_en !== exp_en) en_bad++;
      if (ct_valid) ct_cnt++;
      if (tag_valid) begin
        if (tag_idx !== tag_cnt[6:0]) tag_bad++;
        tag_cnt++;
      end
      case (k)
        0: begin
          chk("init0_phase", phase, 1); chk("init0_src", m_src, 2);
          chk("init0_idx", m_idx, 0); chk("init0_cacb", {ca, cb}, 2'b11);
        end
        127:  begin chk("init127_src", m_src, 2); chk("init127_idx", m_idx, 127); end
        128:  begin chk("init128_src", m_src, 3); chk("init128_idx", m_idx, 0); end
        256:  begin chk("init256_src", m_src, 6); chk("init256_idx", m_idx, 0); end
        257:  begin chk("init257_src", m_src, 2); chk("init257_idx", m_idx, 1); end
        1791: begin
          chk("init1791_phase", phase, 1); chk("init1791_src", m_src, 2);
          chk("init1791_idx", m_idx, 127);
        end
        1792: begin
          chk("ad0_phase", phase, 2); chk("ad0_src", m_src, 4);
          chk("ad0_idx", m_idx, 0); chk("ad0_cacb", {ca, cb}, 2'b11);
        end
        1920: begin chk("ad128_src", m_src, 1); chk("ad128_idx", m_idx, 0); chk("ad128_cacb", {ca, cb}, 2'b11); end
        2048: begin chk("ad256_src", m_src, 0); chk("ad256_cacb", {ca, cb}, 2'b01); end
        2175: begin chk("ad383_phase", phase, 2); chk("ad383_cacb", {ca, cb}, 2'b01); end
        2176: begin
          chk("enc0_phase", phase, 3); chk("enc0_src", m_src, 5);
          chk("enc0_idx", m_idx, 0); chk("enc0_cacb", {ca, cb}, 2'b10);
        end
        2301: begin chk("enc_start_ign_phase", phase, 3); chk("enc_start_ign_idx", m_idx, 125); end
        2303: begin
          chk("enc127_ct", ct_valid, exp_en); chk("enc127_cacb", {ca, cb}, 2'b10);
          chk("enc127_src", m_src, 5); chk("enc127_idx", m_idx, 127);
        end
        2431: begin chk("enc255_cacb", {ca, cb}, 2'b10); chk("enc255_ct", ct_valid, 0); chk("enc255_src", m_src, 0); end
        2432: begin chk("enc256_src", m_src, 0); chk("enc256_idx", m_idx, 0); chk("enc256_cacb", {ca, cb}, 2'b00); end
        2559: chk("enc383_phase", phase, 3);
        2560: begin
          chk("fin0_phase", phase, 4); chk("fin0_src", m_src, 0);
          chk("fin0_cacb", {ca, cb}, 2'b11); chk("fin0_tagv", tag_valid, 0);
          chk("fin0_tagidx", tag_idx, 0);
        end
        3199: begin chk("fin639_tagv", tag_valid, 0); chk("fin639_tagidx", tag_idx, 0); end
        3200: begin chk("fin640_tagv", tag_valid, exp_en); chk("fin640_tagidx", tag_idx, 0); end
        3327: begin
          chk("fin767_phase", phase, 4); chk("fin767_tagv", tag_valid, exp_en);
          chk("fin767_tagidx", tag_idx, 127);
        end
        default: ;
      endcase
      tick();
      cyc++;
      if (exp_en) k++;
    end
    if (stop_k < 0) begin
      chk("ct_count", ct_cnt, 128);
      chk("tag_count", tag_cnt, 128);
      chk("tag_order_bad", tag_bad, 0);
      chk("step_en_bad", en_bad, 0);
    end
  endtask

  task automatic chk_done(input string tag, input int done_k, input int cyc);
    chk({tag, "_done_step"}, done_k, 3328);
`ifndef ACORN_STEP_STALL_EN
    chk({tag, "_done_cycles"}, cyc, 3328);
`endif
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_done_phase"}, phase, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_step_en"}, step_en, 0);
  endtask

  initial begin
    int dk, cy, done_seen;
    rst = 1'b1;
    start = 1'b0;
    step_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_cacb", {ca, cb}, 2'b00);
    chk("rst_src", m_src, 0);
    chk("rst_idx", m_idx, 0);
    chk("rst_ctv", ct_valid, 0);
    chk("rst_tagv", tag_valid, 0);
    chk("rst_tagidx", tag_idx, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // first schedule: start in cycle 0, busy expected in cycle 1
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cycle1_busy", busy, 1);
    run(-1, dk, cy);
    chk_done("run1", dk, cy);

    // start in the done cycle launches INIT on the next cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_phase", phase, 1);
    chk("restart_busy", busy, 1);
    chk("restart_idx", m_idx, 0);
    chk("restart_done", done, 0);

    // abort in FIN at i=300 (k = 2560 + 300)
    run(2860, dk, cy);
    chk("abort_pre_phase", phase, 4);
    chk("abort_pre_cacb", {ca, cb}, 2'b11);
    rst = 1'b1;
    #1;
    chk("abort_phase", phase, 0);
    chk("abort_busy", busy, 0);
    chk("abort_step_en", step_en, 0);
    chk("abort_done", done, 0);
    done_seen = 0;
    repeat (3) begin
      tick();
      if (done) done_seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle", phase, 0);

    // full schedule after the abort
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_abort_busy", busy, 1);
    run(-1, dk, cy);
    chk_done("run2", dk, cy);
    tick();
    chk("after_done_low", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
